// File: rtl/divider_seq_n_if.sv
// Operand/result bundle for divider_seq_n: start handshake, operands in,
// busy/done status and registered results out.
interface divider_seq_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_seq_n.sv
// Sequential restoring divider, one quotient bit per clock, with optional
// two's-complement mode (truncating toward zero) and divide-by-zero flag.
module divider_seq_n #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           resetn,
    divider_seq_n_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] n_raw_q, n_raw_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] n_mag, d_mag;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        zero_d  = zero_q;
        n_raw_d = n_raw_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        n_mag = (SIGNED && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        d_mag = (SIGNED && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
        // Shift {A,Q} left by one and try to subtract D; the top bit is the sign.
        trial = {a_q, q_q[WIDTH-1]} - (WIDTH + 2)'(d_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = '0;
                    q_d     = n_mag;
                    d_d     = d_mag;
                    cnt_d   = '0;
                    sq_d    = SIGNED && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    sr_d    = SIGNED && bus.dividend[WIDTH-1];
                    zero_d  = (bus.divisor == '0);
                    n_raw_d = bus.dividend;
                    state_d = (bus.divisor == '0) ? FIXUP : RUN;
                end
            end
            RUN: begin
                if (!trial[WIDTH+1]) begin
                    a_d = trial[WIDTH:0];
                end else begin
                    a_d = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                end
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = n_raw_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = sq_q ? -q_q : q_q;
                    rem_d  = sr_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all state, including the datapath registers, is cleared by
        // reset so a reset mid-division leaves no stale partial results.
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            zero_q  <= 1'b0;
            n_raw_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the values
            // from before this edge.
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            zero_q  <= zero_d;
            n_raw_q <= n_raw_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_seq_n.sv
// Bench for divider_seq_n: six instances (WIDTH 8/4/16, unsigned and signed)
// checked every cycle against an arithmetic model, plus literal expectations.
module tb_divider_seq_n;
    localparam int NI = 6;
    localparam int CFG_W [NI] = '{8, 8, 4, 4, 16, 16};
    localparam bit CFG_S [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } res_t;

    logic        clk = 1'b0;
    logic        rstn_a  [NI];
    logic        start_a [NI];
    logic [15:0] n_a     [NI];
    logic [15:0] d_a     [NI];
    logic        busy_a  [NI];
    logic        done_a  [NI];
    logic        dbz_a   [NI];
    logic [15:0] q_a     [NI];
    logic [15:0] r_a     [NI];

    int    n_pass = 0;
    int    n_total = 0;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int W = CFG_W[g];
        localparam bit S = CFG_S[g];
        divider_seq_n_if #(.WIDTH(W)) bus ();
        assign bus.start    = start_a[g];
        assign bus.dividend = n_a[g][W-1:0];
        assign bus.divisor  = d_a[g][W-1:0];
        divider_seq_n #(.WIDTH(W), .SIGNED(S)) dut (
            .clk    (clk),
            .resetn (rstn_a[g]),
            .bus    (bus)
        );
        assign busy_a[g] = bus.busy;
        assign done_a[g] = bus.done;
        assign dbz_a[g]  = bus.div_by_zero;
        assign q_a[g]    = 16'(bus.quotient);
        assign r_a[g]    = 16'(bus.remainder);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic longint sx(input logic [15:0] v, input int w, input bit s);
        longint x;
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (s && x[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Reference result straight from the arithmetic definition.
    function automatic res_t ref_div(input int w, input bit s, input logic [15:0] n, input logic [15:0] d);
        longint mask, nn, dd;
        res_t   res;
        mask = (longint'(1) << w) - 1;
        nn = sx(n, w, s);
        dd = sx(d, w, s);
        if (dd == 0) begin
            res.q   = 16'(mask);
            res.r   = 16'(longint'(n) & mask);
            res.dbz = 1'b1;
        end else begin
            res.q   = 16'((nn / dd) & mask);
            res.r   = 16'((nn % dd) & mask);
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    // Model: one pending job with a countdown to its done cycle.
    logic        m_pend [NI];
    logic        m_done [NI];
    int          m_cnt  [NI];
    res_t        m_job  [NI];
    res_t        m_res  [NI];
    logic [15:0] m_n    [NI];
    logic [15:0] m_d    [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rstn_a[i]) begin
                m_pend[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_res[i]  <= '0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_pend[i]) begin
                    if (m_cnt[i] == 1) begin
                        m_pend[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_res[i]  <= m_job[i];
                    end
                    m_cnt[i] <= m_cnt[i] - 1;
                end else if (start_a[i]) begin
                    m_job[i]  <= ref_div(CFG_W[i], CFG_S[i], n_a[i], d_a[i]);
                    m_cnt[i]  <= (sx(d_a[i], CFG_W[i], 1'b0) == 0) ? 1 : CFG_W[i] + 1;
                    m_pend[i] <= 1'b1;
                    m_n[i]    <= n_a[i];
                    m_d[i]    <= d_a[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("inst%0d_busy_done_dbz_q_r", i),
                      {busy_a[i], done_a[i], dbz_a[i], q_a[i], r_a[i]},
                      {m_pend[i], m_done[i], m_res[i].dbz, m_res[i].q, m_res[i].r});
                if (m_done[i] && !m_res[i].dbz) begin
                    longint qs, rs, ds, ns, mask, ar, ad;
                    int w;
                    bit s;
                    w = CFG_W[i];
                    s = CFG_S[i];
                    mask = (longint'(1) << w) - 1;
                    qs = sx(q_a[i], w, s);
                    rs = sx(r_a[i], w, s);
                    ds = sx(m_d[i], w, s);
                    ns = sx(m_n[i], w, s);
                    ar = (rs < 0) ? -rs : rs;
                    ad = (ds < 0) ? -ds : ds;
                    check($sformatf("inst%0d_identity_rbound_rsign", i),
                          {61'd0, ((qs * ds + rs) & mask) == (ns & mask), ar < ad,
                           (rs == 0) || ((rs < 0) == (ns < 0))},
                          64'd7);
                end
            end
        end
    end

    // Drives one operation from a negedge; returns at the negedge of the done
    // cycle (or after a 40-cycle bound). Optional ignored start and reset pulse.
    task automatic run_op(input int i, input logic [15:0] n, input logic [15:0] d,
                          input int inject_at, input int rst_at,
                          output logic [15:0] q, output logic [15:0] r, output logic dbz,
                          output int lat, output int busy_cyc, output bit got_done);
        start_a[i] = 1'b1;
        n_a[i] = n;
        d_a[i] = d;
        @(posedge clk);
        @(negedge clk);
        start_a[i] = 1'b0;
        n_a[i] = 16'($urandom);
        d_a[i] = 16'($urandom);
        busy_cyc = int'(busy_a[i]);
        got_done = done_a[i];
        lat = 0;
        while (lat < 40 && !got_done) begin
            start_a[i] = (lat == inject_at);
            rstn_a[i]  = (lat != rst_at);
            @(posedge clk);
            lat++;
            @(negedge clk);
            start_a[i] = 1'b0;
            rstn_a[i]  = 1'b1;
            if (done_a[i]) got_done = 1'b1;
            else if (busy_a[i]) busy_cyc++;
        end
        q = q_a[i];
        r = r_a[i];
        dbz = dbz_a[i];
    endtask

    logic [15:0] rq, rr;
    logic        rdbz;
    int          rlat, rbusy, ndone;
    bit          rdone;
    longint      t1;

    initial begin
        for (int i = 0; i < NI; i++) begin
            rstn_a[i] = 1'b0;
            start_a[i] = 1'b0;
            n_a[i] = '0;
            d_a[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy_a[0], done_a[0], dbz_a[0], q_a[0], r_a[0]}, 64'd0);
        for (int i = 0; i < NI; i++) rstn_a[i] = 1'b1;
        @(negedge clk);

        run_op(0, 16'd13, 16'd3, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("u8_13_3_latency", rlat, 9);
        check("u8_13_3_busy_cycles", rbusy, 9);
        check("u8_13_3_q_r_dbz", {rq, rr, rdbz}, {16'h04, 16'h01, 1'b0});

        run_op(0, 16'd255, 16'd16, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        t1 = cyc;
        check("u8_255_16_q_r", {rq, rr}, {16'h0F, 16'h0F});
        run_op(0, 16'd7, 16'd9, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("u8_7_9_q_r", {rq, rr}, {16'h00, 16'h07});
        check("u8_back_to_back_gap", cyc - t1, 10);

        run_op(0, 16'h4D, 16'd0, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("u8_div0_latency", rlat, 1);
        check("u8_div0_q_r_dbz", {rq, rr, rdbz}, {16'hFF, 16'h4D, 1'b1});
        run_op(0, 16'd6, 16'd2, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("u8_6_2_q_r_dbz", {rq, rr, rdbz}, {16'h03, 16'h00, 1'b0});

        run_op(1, 16'hF9, 16'h02, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("s8_m7_2_q_r", {rq, rr}, {16'hFD, 16'hFF});
        run_op(1, 16'h07, 16'hFE, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("s8_7_m2_q_r", {rq, rr}, {16'hFD, 16'h01});
        run_op(1, 16'h80, 16'hFF, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("s8_m128_m1_q_r_dbz", {rq, rr, rdbz}, {16'h80, 16'h00, 1'b0});

        run_op(0, 16'd200, 16'd3, 3, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("u8_ignored_start_done_latency", {rdone, 8'(rlat)}, {1'b1, 8'd9});
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_a[0]) ndone++;
        end
        check("u8_ignored_start_no_extra_done", ndone, 0);

        run_op(0, 16'd50, 16'd3, -1, 4, rq, rr, rdbz, rlat, rbusy, rdone);
        check("u8_reset_mid_op_no_done", rdone, 0);
        check("u8_reset_mid_op_outputs", {busy_a[0], dbz_a[0], q_a[0], r_a[0]}, 64'd0);
        run_op(0, 16'd100, 16'd7, -1, -1, rq, rr, rdbz, rlat, rbusy, rdone);
        check("u8_100_7_q_r", {rq, rr}, {16'h0E, 16'h02});

        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 40; k++) begin
                logic [15:0] n, d, mask;
                int inj;
                mask = 16'((32'd1 << CFG_W[i]) - 1);
                n = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: d = 16'd0;
                    1: d = 16'($urandom_range(1, 7));
                    2: begin
                        if (CFG_S[i]) n = 16'(32'd1 << (CFG_W[i] - 1));
                        d = 16'hFFFF;
                    end
                    default: d = 16'($urandom);
                endcase
                inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, CFG_W[i] - 1) : -1;
                run_op(i, n, d, inj, -1, rq, rr, rdbz, rlat, rbusy, rdone);
                check($sformatf("inst%0d_random_latency", i), {rdone, 8'(rlat)},
                      {1'b1, ((d & mask) == 0) ? 8'd1 : 8'(CFG_W[i] + 1)});
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
